// File: rtl/dcache_wb_ctrl_pkg.sv
// Shared types and constants for the write-back L1 data cache controller.
// Pulled in by every dcache_wb_ctrl file through import dcache_pkg::*.
package dcache_pkg;

    localparam int TAG_W      = 22;
    localparam int IDX_W      = 6;
    localparam int LINE_BYTES = 16;
    localparam int LINE_W     = 8 * LINE_BYTES;
    localparam int ADDR_W     = TAG_W + IDX_W;
    localparam int NUM_LINES  = 1 << IDX_W;

    // Line address layout is {tag, index}
    localparam int IDX_LSB = 0;
    localparam int IDX_MSB = IDX_W - 1;
    localparam int TAG_LSB = IDX_W;
    localparam int TAG_MSB = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    typedef logic [ADDR_W-1:0] addr_t;

    function automatic logic [IDX_W-1:0] addr_idx(input addr_t a);
        return a[IDX_MSB:IDX_LSB];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input addr_t a);
        return a[TAG_MSB:TAG_LSB];
    endfunction

endpackage

// File: rtl/dcache_wb_ctrl_if.sv
// Pipeline-side and memory-side signal bundle of the data cache controller.
// slave is the cache's view, master is the view of the pipeline/memory environment.
interface dcache_wb_ctrl_if;
    import dcache_pkg::*;

    logic                  dcache_ren;
    logic                  dcache_wen;
    logic [ADDR_W-1:0]     dcache_addr;
    logic [LINE_BYTES-1:0] byteSelectVector;
    logic [LINE_W-1:0]     dcache_input;
    logic [LINE_W-1:0]     dcache_output;
    logic                  dcache_stall;

    logic                  mem_enable_o;
    logic                  mem_write_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [LINE_W-1:0]     mem_data_o;
    logic [LINE_W-1:0]     mem_data_i;
    logic                  mem_ack_i;

    logic [31:0]           hit_cnt_o;
    logic [31:0]           miss_cnt_o;

    modport slave (
        input  dcache_ren, dcache_wen, dcache_addr, byteSelectVector, dcache_input,
        output dcache_output, dcache_stall,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i,
        output hit_cnt_o, miss_cnt_o
    );

    modport master (
        output dcache_ren, dcache_wen, dcache_addr, byteSelectVector, dcache_input,
        input  dcache_output, dcache_stall,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i,
        input  hit_cnt_o, miss_cnt_o
    );

endinterface

// File: rtl/dcache_line_array.sv
// Direct-mapped line storage: valid/dirty/tag/data with asynchronous read.
// Provides a byte-masked store port, a whole-line fill port and a dirty-clear port.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [LINE_BYTES-1:0] wr_be,
    input  logic [LINE_W-1:0]     wr_data,
    input  logic                  fill_en,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic [LINE_W-1:0]     fill_data,
    input  logic                  clean_en
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    // Only the status bits are reset; tag/data are meaningless while valid is low
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[idx] <= 1'b1;
        end else if (clean_en) begin
            dirty_q[idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_data;
        end else if (wr_en) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (wr_be[b]) begin
                    data_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller (FSM, stall, memory handshake).
// Optional statistics counters are built only when DCACHE_STATS_EN is defined.
module dcache_wb_ctrl
    import dcache_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    dcache_wb_ctrl_if.slave bus
);

    state_t state, state_next;
    addr_t  miss_addr;

    logic              request;
    logic              hit;
    logic              idle_hit;
    logic              idle_miss;
    logic [IDX_W-1:0]  arr_idx;

    logic              rd_valid;
    logic              rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_data;

    logic              wr_en;
    logic              fill_en;
    logic              clean_en;
    logic              stall;
    logic              mem_enable;
    logic              mem_write;
    addr_t             mem_addr;
    logic [LINE_W-1:0] mem_data;
    logic [LINE_W-1:0] load_data;

    assign request = bus.dcache_ren | bus.dcache_wen;

    // During a transfer the array follows the latched miss line, not the live bus address
    assign arr_idx   = (state == IDLE) ? addr_idx(bus.dcache_addr) : addr_idx(miss_addr);
    assign hit       = rd_valid && (rd_tag == addr_tag(bus.dcache_addr));
    assign idle_hit  = (state == IDLE) && request && hit;
    assign idle_miss = (state == IDLE) && request && !hit;

    dcache_line_array u_lines (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idx       (arr_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_be     (bus.byteSelectVector),
        .wr_data   (bus.dcache_input),
        .fill_en   (fill_en),
        .fill_tag  (addr_tag(miss_addr)),
        .fill_data (bus.mem_data_i),
        .clean_en  (clean_en)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state <= state_next;
            if (idle_miss) begin
                miss_addr <= bus.dcache_addr;
            end
        end
    end

    // A dropped request mid-transfer still lets the current transfer finish, then returns to IDLE
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        fill_en    = 1'b0;
        clean_en   = 1'b0;
        stall      = 1'b0;
        mem_enable = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        load_data  = '0;
        case (state)
            IDLE: begin
                if (hit) begin
                    load_data = rd_data;
                end
                if (request) begin
                    if (hit) begin
                        wr_en = bus.dcache_wen;
                    end else begin
                        stall      = 1'b1;
                        state_next = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                stall      = request;
                mem_enable = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {rd_tag, addr_idx(miss_addr)};
                mem_data   = rd_data;
                if (bus.mem_ack_i) begin
                    clean_en   = 1'b1;
                    state_next = request ? ALLOCATE : IDLE;
                end
            end
            ALLOCATE: begin
                stall      = request;
                mem_enable = 1'b1;
                mem_addr   = miss_addr;
                if (bus.mem_ack_i) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.dcache_stall  = stall && !rst_i;
    assign bus.dcache_output = load_data;
    assign bus.mem_enable_o  = mem_enable;
    assign bus.mem_write_o   = mem_write;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_data_o    = mem_data;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (idle_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (idle_miss) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign bus.hit_cnt_o  = hit_cnt_q;
    assign bus.miss_cnt_o = miss_cnt_q;
`else
    assign bus.hit_cnt_o  = 32'd0;
    assign bus.miss_cnt_o = 32'd0;
`endif

endmodule
